serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder with a small control FSM. On an accepted start the
//   operands are captured into shift registers, then one bit per clock is
//   summed LSB first through a single full-adder slice (two half adders plus
//   a 1-bit carry flop). The partial sum is shifted into an accumulator from
//   the MSB end, so after WIDTH bits it is aligned and is copied to sum.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      begin an addition (honoured only in IDLE)
//   a, b   in   WIDTH  operands, captured on the accepting edge only
//   busy   out  1      high in RUN and DONE
//   done   out  1      one-cycle pulse when sum/carry hold a new result
//   sum    out  WIDTH  registered a+b modulo 2^WIDTH
//   carry  out  1      registered carry-out of the MSB
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // Counter holds 0..WIDTH, so it never wraps during an operation.
    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    logic             w_h1;
    logic             w_c1;
    logic             w_bit;
    logic             w_c2;
    logic             w_cnext;
    logic [WIDTH-1:0] w_acc_next;

    // Full-adder slice built from two half adders; carry-out is the OR of
    // the two half-adder carries (equivalent to majority(a_i, b_i, c)).
    always_comb begin
        w_h1       = r_a[0] ^ r_b[0];
        w_c1       = r_a[0] & r_b[0];
        w_bit      = w_h1 ^ r_c;
        w_c2       = w_h1 & r_c;
        w_cnext    = w_c1 | w_c2;
        // New bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
        w_acc_next = r_acc >> 1;
        w_acc_next[WIDTH-1] = w_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            carry   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= '0;
                        r_c     <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_cnext;
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        // Final bit: publish result straight from the slice.
                        sum     <= w_acc_next;
                        carry   <= w_cnext;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
